// File: rtl/gates_checker.sv
// gates_checker: compares a six-gate DUT response against the expected vector over a run of N_VECTORS compares.
// Optional macro GATES_CHECKER_FAIL_LOG_EN adds a first_fail capture port.
`default_nettype none

module gates_checker #(
  parameter int LATENCY   = 1,
  parameter int N_VECTORS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        valid,
  input  logic        a,
  input  logic        b,
  input  logic [5:0]  z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch,
  output logic [7:0]  err_cnt,
  output logic [15:0] vec_cnt,
  output logic [3:0]  cov
`ifdef GATES_CHECKER_FAIL_LOG_EN
  ,
  output logic [9:0]  first_fail
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic        run_start, push, cmp, last, pipe_clr, miss;
  logic        d_v, d_a, d_b;
  logic [5:0]  expected;

  always_comb begin
    run_start = start && (state != RUN);
    push      = valid && (state == RUN);
    cmp       = d_v && (state == RUN);
    last      = cmp && (vec_cnt == 16'(N_VECTORS - 1));
    // Clearing at the end of a run drops in-flight entries so they are never counted.
    pipe_clr  = run_start || last;
    expected  = {~(d_a ^ d_b), d_a ^ d_b, ~(d_a | d_b), d_a | d_b, ~(d_a & d_b), d_a & d_b};
    miss      = cmp && (z != expected);
  end

  generate
    if (LATENCY == 0) begin : g_no_delay
      assign d_v = valid;
      assign d_a = a;
      assign d_b = b;
    end else begin : g_delay
      logic [LATENCY-1:0] pv, pa, pb;
      always_ff @(posedge clk) begin
        if (rst || pipe_clr) begin
          pv <= '0;
          pa <= '0;
          pb <= '0;
        end else begin
          pv[0] <= push;
          pa[0] <= a;
          pb[0] <= b;
          for (int i = 1; i < LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
          end
        end
      end
      assign d_v = pv[LATENCY-1];
      assign d_a = pa[LATENCY-1];
      assign d_b = pb[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state == RUN);
    pass     = (state == DONE) && (err_cnt == 8'd0) && (cov == 4'hF);
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= 8'd0;
      vec_cnt  <= 16'd0;
      cov      <= 4'd0;
    end else begin
      done     <= last;
      mismatch <= miss;
      if (run_start) begin
        err_cnt <= 8'd0;
        vec_cnt <= 16'd0;
        cov     <= 4'd0;
      end else if (cmp) begin
        vec_cnt <= vec_cnt + 16'd1;
        if (miss && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        cov[{d_a, d_b}] <= 1'b1;
      end
    end
  end

`ifdef GATES_CHECKER_FAIL_LOG_EN
  // Bit 1 is the valid flag, so it also marks that a failure has been captured.
  always_ff @(posedge clk) begin
    if (rst || run_start)
      first_fail <= 10'd0;
    else if (miss && !first_fail[1])
      first_fail <= {d_a, d_b, z, 1'b1, 1'b0};
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gates_checker.sv
// Directed self-checking bench for gates_checker across several LATENCY / N_VECTORS builds.
`default_nettype none

module tb_gates_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, valid = 1'b0, a = 1'b0, b = 1'b0;
  logic [5:0] z;
  logic [5:0] zd1 = 6'd0, zd2 = 6'd0;
  int         sel_src = 1;
  bit         xor_fault = 1'b0, stuck0 = 1'b0;
  int         checks = 0, failures = 0;

  logic        busy_v [4], done_v [4], pass_v [4], mis_v [4];
  logic [7:0]  err_v  [4];
  logic [15:0] vec_v  [4];
  logic [3:0]  cov_v  [4];
`ifdef GATES_CHECKER_FAIL_LOG_EN
  logic [9:0]  ff_v   [4];
`endif

  function automatic logic [5:0] gates(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), x | y, ~(x & y), x & y};
  endfunction

  function automatic logic [1:0] pat_ab(input int pat, input int cyc);
    if (pat == 0) return 2'(cyc % 4);
    return (cyc % 2 == 0) ? 2'b00 : 2'b11;
  endfunction

  // Reference gate DUT with selectable response delay and fault injection.
  always @(posedge clk) begin
    zd1 <= gates(a, b);
    zd2 <= zd1;
  end

  always_comb begin
    z = (sel_src == 0) ? gates(a, b) : (sel_src == 1) ? zd1 : zd2;
    if (xor_fault) z[4] = 1'b0;
    if (stuck0) z = 6'd0;
  end

  gates_checker #(.LATENCY(1), .N_VECTORS(16)) u_l1 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .z(z),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .mismatch(mis_v[0]),
    .err_cnt(err_v[0]), .vec_cnt(vec_v[0]), .cov(cov_v[0])
`ifdef GATES_CHECKER_FAIL_LOG_EN
    , .first_fail(ff_v[0])
`endif
  );

  gates_checker #(.LATENCY(2), .N_VECTORS(16)) u_l2 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .z(z),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .mismatch(mis_v[1]),
    .err_cnt(err_v[1]), .vec_cnt(vec_v[1]), .cov(cov_v[1])
`ifdef GATES_CHECKER_FAIL_LOG_EN
    , .first_fail(ff_v[1])
`endif
  );

  gates_checker #(.LATENCY(1), .N_VECTORS(300)) u_n300 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .z(z),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .mismatch(mis_v[2]),
    .err_cnt(err_v[2]), .vec_cnt(vec_v[2]), .cov(cov_v[2])
`ifdef GATES_CHECKER_FAIL_LOG_EN
    , .first_fail(ff_v[2])
`endif
  );

  gates_checker #(.LATENCY(0), .N_VECTORS(4)) u_l0 (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .a(a), .b(b), .z(z),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .mismatch(mis_v[3]),
    .err_cnt(err_v[3]), .vec_cnt(vec_v[3]), .cov(cov_v[3])
`ifdef GATES_CHECKER_FAIL_LOG_EN
    , .first_fail(ff_v[3])
`endif
  );

  task automatic apply_reset(input logic start_during);
    @(posedge clk); #1;
    rst = 1'b1; start = start_during; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
  endtask

  // Pulses start, then streams valid vectors until done plus three cycles, bounded.
  task automatic run_vectors(input int idx, input int pat, input int nvec,
                             output int n_done, output int n_mis,
                             output logic busy0, output logic pass0);
    int after;
    n_done = 0; n_mis = 0; after = -1; busy0 = 1'b0; pass0 = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < nvec + 12; cyc++) begin
      valid = 1'b1;
      {a, b} = pat_ab(pat, cyc);
      @(negedge clk);
      if (cyc == 0) begin busy0 = busy_v[idx]; pass0 = pass_v[idx]; end
      if (done_v[idx]) n_done++;
      if (mis_v[idx]) n_mis++;
      if (done_v[idx] && after < 0) after = 0;
      if (after >= 0) after++;
      if (after == 4) break;
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset(1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_v[i] !== 1'b0)  begin failures++; $display("FAIL reset_busy[%0d] got=%0b exp=0", i, busy_v[i]); end
      checks++; if (done_v[i] !== 1'b0)  begin failures++; $display("FAIL reset_done[%0d] got=%0b exp=0", i, done_v[i]); end
      checks++; if (pass_v[i] !== 1'b0)  begin failures++; $display("FAIL reset_pass[%0d] got=%0b exp=0", i, pass_v[i]); end
      checks++; if (mis_v[i] !== 1'b0)   begin failures++; $display("FAIL reset_mismatch[%0d] got=%0b exp=0", i, mis_v[i]); end
      checks++; if (err_v[i] !== 8'd0)   begin failures++; $display("FAIL reset_err[%0d] got=%0d exp=0", i, err_v[i]); end
      checks++; if (vec_v[i] !== 16'd0)  begin failures++; $display("FAIL reset_vec[%0d] got=%0d exp=0", i, vec_v[i]); end
      checks++; if (cov_v[i] !== 4'd0)   begin failures++; $display("FAIL reset_cov[%0d] got=%h exp=0", i, cov_v[i]); end
`ifdef GATES_CHECKER_FAIL_LOG_EN
      checks++; if (ff_v[i] !== 10'd0)   begin failures++; $display("FAIL reset_first_fail[%0d] got=%h exp=0", i, ff_v[i]); end
`endif
    end
  endtask

  task automatic test_clean_run;
    int nd, nm; logic b0, p0;
    sel_src = 1; xor_fault = 0; stuck0 = 0;
    apply_reset(1'b0);
    run_vectors(0, 0, 16, nd, nm, b0, p0);
    checks++; if (b0 !== 1'b1)          begin failures++; $display("FAIL clean_busy_in_run got=%0b exp=1", b0); end
    checks++; if (p0 !== 1'b0)          begin failures++; $display("FAIL clean_pass_in_run got=%0b exp=0", p0); end
    checks++; if (nd !== 1)             begin failures++; $display("FAIL clean_done_pulses got=%0d exp=1", nd); end
    checks++; if (nm !== 0)             begin failures++; $display("FAIL clean_mismatch_pulses got=%0d exp=0", nm); end
    checks++; if (vec_v[0] !== 16'd16)  begin failures++; $display("FAIL clean_vec got=%0d exp=16", vec_v[0]); end
    checks++; if (err_v[0] !== 8'd0)    begin failures++; $display("FAIL clean_err got=%0d exp=0", err_v[0]); end
    checks++; if (cov_v[0] !== 4'hF)    begin failures++; $display("FAIL clean_cov got=%h exp=f", cov_v[0]); end
    checks++; if (pass_v[0] !== 1'b1)   begin failures++; $display("FAIL clean_pass got=%0b exp=1", pass_v[0]); end
    checks++; if (busy_v[0] !== 1'b0)   begin failures++; $display("FAIL clean_busy_done got=%0b exp=0", busy_v[0]); end
  endtask

  task automatic test_xor_fault;
    int nd, nm; logic b0, p0;
    sel_src = 1; xor_fault = 1; stuck0 = 0;
    apply_reset(1'b0);
    run_vectors(0, 0, 16, nd, nm, b0, p0);
    xor_fault = 0;
    checks++; if (nd !== 1)             begin failures++; $display("FAIL xor_done_pulses got=%0d exp=1", nd); end
    checks++; if (nm !== 8)             begin failures++; $display("FAIL xor_mismatch_pulses got=%0d exp=8", nm); end
    checks++; if (err_v[0] !== 8'd8)    begin failures++; $display("FAIL xor_err got=%0d exp=8", err_v[0]); end
    checks++; if (cov_v[0] !== 4'hF)    begin failures++; $display("FAIL xor_cov got=%h exp=f", cov_v[0]); end
    checks++; if (pass_v[0] !== 1'b0)   begin failures++; $display("FAIL xor_pass got=%0b exp=0", pass_v[0]); end
`ifdef GATES_CHECKER_FAIL_LOG_EN
    checks++; if (ff_v[0] !== 10'h11A)  begin failures++; $display("FAIL xor_first_fail got=%h exp=11a", ff_v[0]); end
`endif
  endtask

  task automatic test_partial_cov;
    int nd, nm; logic b0, p0;
    sel_src = 1; xor_fault = 0; stuck0 = 0;
    apply_reset(1'b0);
    run_vectors(0, 1, 16, nd, nm, b0, p0);
    checks++; if (nd !== 1)             begin failures++; $display("FAIL partial_done_pulses got=%0d exp=1", nd); end
    checks++; if (err_v[0] !== 8'd0)    begin failures++; $display("FAIL partial_err got=%0d exp=0", err_v[0]); end
    checks++; if (cov_v[0] !== 4'b1001) begin failures++; $display("FAIL partial_cov got=%b exp=1001", cov_v[0]); end
    checks++; if (pass_v[0] !== 1'b0)   begin failures++; $display("FAIL partial_pass got=%0b exp=0", pass_v[0]); end
  endtask

  task automatic test_latency2;
    int nd, nm; logic b0, p0;
    sel_src = 1; xor_fault = 0; stuck0 = 0;
    apply_reset(1'b0);
    run_vectors(1, 0, 16, nd, nm, b0, p0);
    checks++; if (err_v[1] !== 8'd12)   begin failures++; $display("FAIL lat2_short_err got=%0d exp=12", err_v[1]); end
    checks++; if (pass_v[1] !== 1'b0)   begin failures++; $display("FAIL lat2_short_pass got=%0b exp=0", pass_v[1]); end
    sel_src = 2;
    run_vectors(1, 0, 16, nd, nm, b0, p0);
    checks++; if (nd !== 1)             begin failures++; $display("FAIL lat2_done_pulses got=%0d exp=1", nd); end
    checks++; if (err_v[1] !== 8'd0)    begin failures++; $display("FAIL lat2_err got=%0d exp=0", err_v[1]); end
    checks++; if (vec_v[1] !== 16'd16)  begin failures++; $display("FAIL lat2_vec got=%0d exp=16", vec_v[1]); end
    checks++; if (pass_v[1] !== 1'b1)   begin failures++; $display("FAIL lat2_pass got=%0b exp=1", pass_v[1]); end
  endtask

  task automatic test_latency0;
    int nd, nm; logic b0, p0;
    sel_src = 0; xor_fault = 0; stuck0 = 0;
    apply_reset(1'b0);
    run_vectors(3, 0, 4, nd, nm, b0, p0);
    checks++; if (nd !== 1)             begin failures++; $display("FAIL lat0_done_pulses got=%0d exp=1", nd); end
    checks++; if (vec_v[3] !== 16'd4)   begin failures++; $display("FAIL lat0_vec got=%0d exp=4", vec_v[3]); end
    checks++; if (pass_v[3] !== 1'b1)   begin failures++; $display("FAIL lat0_pass got=%0b exp=1", pass_v[3]); end
  endtask

  task automatic test_reset_mid;
    int nd, nm, seen_done; bit found; logic b0, p0;
    sel_src = 1; xor_fault = 0; stuck0 = 0;
    apply_reset(1'b0);
    seen_done = 0; found = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      valid = 1'b1;
      {a, b} = pat_ab(0, cyc);
      @(negedge clk);
      if (done_v[0]) seen_done++;
      if (vec_v[0] == 16'd5) begin found = 1; break; end
      @(posedge clk); #1;
    end
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    if (done_v[0]) seen_done++;
    checks++; if (found !== 1'b1)       begin failures++; $display("FAIL midrst_reached5 got=%0b exp=1", found); end
    checks++; if (busy_v[0] !== 1'b0)   begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy_v[0]); end
    checks++; if (vec_v[0] !== 16'd0)   begin failures++; $display("FAIL midrst_vec got=%0d exp=0", vec_v[0]); end
    checks++; if (cov_v[0] !== 4'd0)    begin failures++; $display("FAIL midrst_cov got=%h exp=0", cov_v[0]); end
    checks++; if (seen_done !== 0)      begin failures++; $display("FAIL midrst_done_pulses got=%0d exp=0", seen_done); end
    run_vectors(0, 0, 16, nd, nm, b0, p0);
    checks++; if (nd !== 1)             begin failures++; $display("FAIL midrst_rerun_done got=%0d exp=1", nd); end
    checks++; if (vec_v[0] !== 16'd16)  begin failures++; $display("FAIL midrst_rerun_vec got=%0d exp=16", vec_v[0]); end
    checks++; if (pass_v[0] !== 1'b1)   begin failures++; $display("FAIL midrst_rerun_pass got=%0b exp=1", pass_v[0]); end
  endtask

  task automatic test_saturate;
    int nd, nm; logic b0, p0;
    sel_src = 1; xor_fault = 0; stuck0 = 1;
    apply_reset(1'b0);
    run_vectors(2, 0, 300, nd, nm, b0, p0);
    stuck0 = 0;
    checks++; if (nd !== 1)             begin failures++; $display("FAIL sat_done_pulses got=%0d exp=1", nd); end
    checks++; if (nm !== 300)           begin failures++; $display("FAIL sat_mismatch_pulses got=%0d exp=300", nm); end
    checks++; if (err_v[2] !== 8'd255)  begin failures++; $display("FAIL sat_err got=%0d exp=255", err_v[2]); end
    checks++; if (vec_v[2] !== 16'd300) begin failures++; $display("FAIL sat_vec got=%0d exp=300", vec_v[2]); end
    checks++; if (pass_v[2] !== 1'b0)   begin failures++; $display("FAIL sat_pass got=%0b exp=0", pass_v[2]); end
`ifdef GATES_CHECKER_FAIL_LOG_EN
    checks++; if (ff_v[2] !== 10'h002)  begin failures++; $display("FAIL sat_first_fail got=%h exp=002", ff_v[2]); end
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_xor_fault();
    test_partial_cov();
    test_latency2();
    test_latency0();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gates_checker.md
GATES_CHECKER -- requirements
Module: gates_checker

Interface
REQ-001 Parameter LATENCY, default 1, cycles from stimulus sample to DUT response sample; legal range 0..3.
REQ-002 Parameter N_VECTORS, default 16, number of compares per run; legal range 1..65535.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a run.
REQ-006 valid  input  1  stimulus a/b is applied to the DUT this cycle.
REQ-007 a  input  1  DUT input A.
REQ-008 b  input  1  DUT input B.
REQ-009 z  input  6  DUT response: z[0] AND, z[1] NAND, z[2] OR, z[3] NOR, z[4] XOR, z[5] XNOR.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse on RUN->DONE.
REQ-012 pass  output  1  valid in DONE: no errors and full coverage.
REQ-013 mismatch  output  1  registered, high one cycle per failing compare.
REQ-014 err_cnt  output  8  failing compares this run, saturating.
REQ-015 vec_cnt  output  16  compares performed this run.
REQ-016 cov  output  4  cov[{a,b}] set once that input pair is compared.

Function
REQ-017 Expected vector: {~(a^b), a^b, ~(a|b), a|b, ~(a&b), a&b}, computed from the sampled a,b.
REQ-018 {valid, a, b} enter a LATENCY-deep shift register; the compare uses the delayed entry against the current z.
REQ-019 LATENCY=0: compare current a,b against current z with no delay stage.
REQ-020 A compare occurs only when the delayed valid is high and the state is RUN.
REQ-021 Compare results (mismatch, counters, cov) are registered and visible one cycle after the compare cycle.
REQ-022 FSM states: IDLE, RUN, DONE.
REQ-023 IDLE->RUN on start; counters, cov and pipeline are cleared on this transition.
REQ-024 RUN->DONE in the cycle the N_VECTORS-th compare is registered; done pulses in the same cycle.
REQ-025 DONE->RUN on start, with the same clearing as REQ-023; otherwise DONE holds all outputs.
REQ-026 start in RUN is ignored.
REQ-027 valid in IDLE or DONE is ignored and does not enter the pipeline.
REQ-028 In-flight pipeline entries at RUN->DONE are discarded and never counted.
REQ-029 err_cnt saturates at 255; vec_cnt does not wrap, because it is bounded by N_VECTORS.
REQ-030 pass = (err_cnt==0) && (cov==4'hF), evaluated in DONE; pass is 0 in IDLE and RUN.
REQ-031 A single compare with multiple differing z bits counts as one error.

Reset
REQ-032 rst forces IDLE and clears pipeline, busy, done, pass, mismatch, err_cnt, vec_cnt and cov to 0.
REQ-033 rst has priority over start.
REQ-034 rst mid-run aborts the run with no done pulse.

Configuration
REQ-035 Macro GATES_CHECKER_FAIL_LOG_EN defined adds output first_fail[9:0] = {a, b, z[5:0], valid_flag, 1'b0}, where valid_flag = 1.
REQ-036 With the macro, first_fail captures the first failing compare of the run and holds until the next run start or rst; it is 0 until then.
REQ-037 Without the macro, the first_fail port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 Scenario: LATENCY=1, N_VECTORS=16, correct gate model driven by a 2-bit counter with valid=1 -> done pulses once, vec_cnt=16, err_cnt=0, cov=4'hF, pass=1.
REQ-039 Scenario: same setup, z[4] forced to 0 -> errors occur for ab=01 and 10, so err_cnt=8, pass=0, and mismatch pulses 8 times.
REQ-040 Scenario: only ab=00 and 11 driven for 16 vectors with a correct model -> err_cnt=0, cov=4'b1001, pass=0.
REQ-041 Scenario: LATENCY=2 with the DUT response delayed by 1 cycle -> err_cnt is nonzero; with the response delayed by 2 cycles -> pass=1.
REQ-042 Scenario: rst asserted after 5 compares -> IDLE, all counters 0, no done pulse; a following start yields a clean 16-compare pass.
REQ-043 Scenario: N_VECTORS=300 with z stuck at 0 -> err_cnt saturates at 255, vec_cnt=300; with the macro defined, first_fail={a,b,6'h00,1,0} of the first failing vector.
